transfer_center_tx: RTL and testbench
=====================================

Name: transfer_center_tx

Overview:
- Serial transmitter for the transfer-center link. Serialises 8-bit command frames, plus an optional data frame after a BINARY command, onto a single unframed bit line.
- Frame alignment is implicit. Both ends share clk and rst, and each frame is 8 clocks, MSB first. The receiving transfer center recovers bytes from its own free-running 3-bit counter.
- Sits on the scanner/controller side and drives the receiver's dataIn. ready_for_transfer passes through to the peer.

Parameters:
- IDLE_BYTE, 8'h00, filler frame sent when nothing is pending. It is not a legal command, so the receiver ignores it.

Ports:
- clk  input  1  system clock, shared with the receiver
- rst  input  1  asynchronous, active-high reset
- req_valid  input  1  request strobe from the local controller
- req_cmd  input  8  command code, legal values 1..8 (see package)
- req_data  input  8  payload byte, used only when req_cmd==CMD_BINARY
- req_ready  output  1  holding register empty; a request is accepted on a clk edge with req_valid&&req_ready
- peer_ready_in  input  1  receiver-side ready; gates the start of new command frames
- ready_for_transfer_out  output  1  combinational copy of peer_ready_in
- serial_out  output  1  registered serial bit, feeds the receiver's dataIn
- frame_start  output  1  registered one-cycle pulse in the clock after a frame's MSB is loaded
- busy  output  1  high while a command or data frame (not filler) is on the line, or a request is pending
- cmd_err  output  1  one-cycle pulse when an illegal req_cmd is accepted

Behaviour:
- Reset (async, any time, including mid-frame):
  - bit_cnt=3'd7, shift=IDLE_BYTE, serial_out=0, pending=0, state=IDLE
  - req_ready=1, frame_start=0, busy=0, cmd_err=0
  - The partially sent frame and any pending request are discarded.
- bit_cnt: free-running, +1 every clk and wraps 7->0. A "load edge" is a clk edge where bit_cnt==7 before the edge, i.e. the 1st, 9th, 17th... edges after reset release. This matches the receiver's counter, which also resets to 7.
- Load edge:
  - shift <= next byte, and serial_out <= next byte[7].
  - frame_start pulses in the following cycle.
- Other edges: serial_out <= shift[6], shift <= shift<<1. Bits 6..0 go out on the next 7 edges.
- Result: the receiver samples the frame byte on edges 2..9 and latches it at edge 9.
- Next-byte select at a load edge, in priority order:
  1. state==CMD_BIN (the BINARY command just finished): load data_hold, state->DATA.
  2. pending && peer_ready_in: load cmd_hold and clear pending. state->CMD_BIN if cmd_hold==CMD_BINARY, else CMD.
  3. Otherwise: load IDLE_BYTE, state->IDLE.
- The data frame is never gated by peer_ready_in. A CMD_BINARY+data pair is atomic.
- Acceptance:
  - req_ready = !pending.
  - On accept with a legal code (1..8): cmd_hold<=req_cmd, data_hold<=req_data, pending<=1.
  - On accept with an illegal code (0 or >8): not stored; cmd_err pulses and pending stays 0.
- Simultaneous accept and load edge: the load uses the pre-edge pending, so the new request goes out at the next load edge. req_ready goes high in the cycle after pending clears.
- Latency: a request accepted when pending==0 with peer ready starts its MSB at the first load edge strictly after the accept edge. That is 1..8 clocks, then 8 clocks per frame.
- peer_ready_in low: a pending request holds indefinitely and IDLE_BYTE frames repeat. A frame already in flight always completes.
- busy = pending || state!=IDLE.

Decomposition:
- Package transfer_pkg holds:
  - command constants CMD_50=1, CMD_80=2, CMD_90=3, CMD_100=4, CMD_FLUSH=5, CMD_READY=6, CMD_BINARY=7, CMD_ASCII=8
  - IDLE_BYTE, FRAME_BITS=8
  - tx state enum {IDLE, CMD, CMD_BIN, DATA}
  - a legal-command function
- One natural sub-module: tx_shift8. It holds the 8-bit load/shift register plus the 3-bit frame counter and exposes load_edge, load, byte_in and serial_out. FSM and holding register stay in the top.

Test Plan:
- Reset release, no requests -> serial_out stays 0. After 40 clocks the receiver still holds commandBuffer=0 and localScannerOut=0.
- Accept CMD_50 (8'h01) two cycles after reset release -> bits 0,0,0,0,0,0,0,1 on edges 10..17 (first load edge after the accept). The receiver shows commandBuffer=8'h01 and localScannerOut=2'b10. frame_start pulses once. busy falls after the frame.
- Accept CMD_BINARY with req_data=8'hA5 -> frames 8'h07 then 8'hA5 back to back. The receiver shows dataBuffer=8'hA5 and commandBuffer=8'h07.
- peer_ready_in=0 with CMD_90 pending -> only 8'h00 frames for 5 frames and req_ready=0. Raise peer_ready_in -> 8'h03 is sent at the next load edge and localScannerOut=2'b01.
- req_cmd=8'h09 accepted -> cmd_err pulses one cycle, the line stays 8'h00, and req_ready stays 1.
- rst asserted on bit 4 of an 8'h03 frame -> serial_out=0 and req_ready=1 immediately. After release, a new CMD_50 frames correctly on the 9th-edge boundary.

Source files
------------

// File: rtl/transfer_pkg.sv
// Shared definitions for the transfer-center serial link.
// Holds the command codes, the filler byte, the frame length, the
// transmitter state encoding, and a helper that checks command legality.
package transfer_pkg;

    // Command codes understood by the receiving transfer center.
    localparam logic [7:0] CMD_50     = 8'd1;
    localparam logic [7:0] CMD_80     = 8'd2;
    localparam logic [7:0] CMD_90     = 8'd3;
    localparam logic [7:0] CMD_100    = 8'd4;
    localparam logic [7:0] CMD_FLUSH  = 8'd5;
    localparam logic [7:0] CMD_READY  = 8'd6;
    localparam logic [7:0] CMD_BINARY = 8'd7;
    localparam logic [7:0] CMD_ASCII  = 8'd8;

    // Filler frame. The receiver ignores it because it is not a legal command.
    localparam logic [7:0] IDLE_BYTE  = 8'h00;

    // Clocks per frame on the unframed line.
    localparam int unsigned FRAME_BITS = 8;

    // Describes what is currently on the line.
    //   IDLE    : filler frame
    //   CMD     : a command frame with no payload
    //   CMD_BIN : a BINARY command frame; its data frame follows it
    //   DATA    : the data frame that belongs to a BINARY command
    typedef enum logic [1:0] {
        IDLE,
        CMD,
        CMD_BIN,
        DATA
    } tx_state_e;

    function automatic logic is_legal_cmd(input logic [7:0] code);
        return (code >= CMD_50) && (code <= CMD_ASCII);
    endfunction

endpackage

// File: rtl/transfer_center_tx_if.sv
// Request channel from the local controller into the transmitter.
// Ports:
//   req_valid : request strobe (controller -> transmitter)
//   req_cmd   : 8-bit command code
//   req_data  : 8-bit payload, meaningful only with CMD_BINARY
//   req_ready : the holding register is empty (transmitter -> controller)
// A request is taken on a clock edge where req_valid && req_ready.
interface transfer_center_tx_if;

    logic       req_valid;
    logic [7:0] req_cmd;
    logic [7:0] req_data;
    logic       req_ready;

    modport master (
        output req_valid,
        output req_cmd,
        output req_data,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  req_cmd,
        input  req_data,
        output req_ready
    );

endinterface

// File: rtl/tx_shift8.sv
// Shift register and frame counter that drive the serial line.
// The 3-bit counter runs freely from a reset value of 7, which matches the
// receiver's counter. A "load edge" is an edge where the counter reads 7
// before the edge. On that edge byte_in is loaded and its MSB goes straight
// to the line. On every other edge the next bit is shifted out, MSB first.
// Ports:
//   clk, rst   : system clock; asynchronous active-high reset
//   load       : when high, load byte_in on this edge (the top ties it to load_edge)
//   byte_in    : byte to load
//   load_edge  : high during the cycle that ends in a load edge
//   serial_out : registered serial bit
module tx_shift8
    import transfer_pkg::*;
#(
    parameter logic [7:0] RESET_BYTE = 8'h00
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] byte_in,
    output logic       load_edge,
    output logic       serial_out
);

    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shift_q,   shift_d;
    logic       serial_q,  serial_d;

    assign load_edge  = (bit_cnt_q == 3'(FRAME_BITS - 1));
    assign serial_out = serial_q;

    always_comb begin
        // The 3-bit add wraps 7 -> 0 naturally.
        bit_cnt_d = bit_cnt_q + 3'd1;
        shift_d   = shift_q;
        serial_d  = serial_q;
        if (load) begin
            // The MSB goes to the line at the load edge itself, so the
            // register keeps the whole byte. Bits 6..0 follow from shift_q[6].
            shift_d  = byte_in;
            serial_d = byte_in[7];
        end else begin
            serial_d = shift_q[6];
            shift_d  = {shift_q[6:0], 1'b0};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt_q <= 3'd7;
            shift_q   <= RESET_BYTE;
            serial_q  <= 1'b0;
        end else begin
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            serial_q  <= serial_d;
        end
    end

endmodule

// File: rtl/transfer_center_tx.sv
// Transfer-center serial transmitter.
// Serialises 8-bit command frames onto a single unframed bit line. A BINARY
// command is followed by its data frame. Filler frames (IDLE_BYTE) are sent
// when nothing is pending. Frame boundaries are implied by a free-running
// counter that the receiver shares through the common clk/rst.
// Ports:
//   clk, rst               : system clock; asynchronous active-high reset
//   req                    : request channel (valid/cmd/data/ready), slave side
//   peer_ready_in          : receiver ready; gates the start of new command frames
//   ready_for_transfer_out : combinational copy of peer_ready_in
//   serial_out             : registered serial bit to the receiver's dataIn
//   frame_start            : one-cycle pulse after a command or data frame's MSB is loaded
//   busy                   : a command/data frame is on the line or a request is pending
//   cmd_err                : one-cycle pulse after an illegal command is accepted
module transfer_center_tx #(
    parameter logic [7:0] IDLE_BYTE = transfer_pkg::IDLE_BYTE
) (
    input  logic                        clk,
    input  logic                        rst,
    transfer_center_tx_if.slave         req,
    input  logic                        peer_ready_in,
    output logic                        ready_for_transfer_out,
    output logic                        serial_out,
    output logic                        frame_start,
    output logic                        busy,
    output logic                        cmd_err
);

    import transfer_pkg::*;

    tx_state_e  state_q,       state_d;
    logic       pending_q,     pending_d;
    logic [7:0] cmd_hold_q,    cmd_hold_d;
    logic [7:0] data_hold_q,   data_hold_d;
    logic       frame_start_q, frame_start_d;
    logic       cmd_err_q,     cmd_err_d;

    logic       load_edge;
    logic [7:0] next_byte;
    logic       accept;

    assign ready_for_transfer_out = peer_ready_in;
    assign req.req_ready          = !pending_q;
    assign accept                 = req.req_valid && !pending_q;
    assign busy                   = pending_q || (state_q != IDLE);
    assign frame_start            = frame_start_q;
    assign cmd_err                = cmd_err_q;

    tx_shift8 #(
        .RESET_BYTE (IDLE_BYTE)
    ) u_shift (
        .clk        (clk),
        .rst        (rst),
        .load       (load_edge),
        .byte_in    (next_byte),
        .load_edge  (load_edge),
        .serial_out (serial_out)
    );

    always_comb begin
        state_d       = state_q;
        pending_d     = pending_q;
        cmd_hold_d    = cmd_hold_q;
        data_hold_d   = data_hold_q;
        next_byte     = IDLE_BYTE;
        frame_start_d = 1'b0;
        cmd_err_d     = 1'b0;

        // Select the next frame. The data frame of a BINARY command is never
        // gated by the peer, so the command/data pair stays atomic.
        if (load_edge) begin
            if (state_q == CMD_BIN) begin
                next_byte = data_hold_q;
                state_d   = DATA;
            end else if (pending_q && peer_ready_in) begin
                next_byte = cmd_hold_q;
                pending_d = 1'b0;
                state_d   = (cmd_hold_q == CMD_BINARY) ? CMD_BIN : CMD;
            end else begin
                next_byte = IDLE_BYTE;
                state_d   = IDLE;
            end
            frame_start_d = (state_d != IDLE);
        end

        // Acceptance needs pending_q == 0, and the load branch that clears
        // pending needs pending_q == 1, so the two never both write pending_d.
        // A request accepted on a load edge therefore waits for the next one.
        if (accept) begin
            if (is_legal_cmd(req.req_cmd)) begin
                cmd_hold_d  = req.req_cmd;
                data_hold_d = req.req_data;
                pending_d   = 1'b1;
            end else begin
                cmd_err_d   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            pending_q     <= 1'b0;
            cmd_hold_q    <= '0;
            data_hold_q   <= '0;
            frame_start_q <= 1'b0;
            cmd_err_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            pending_q     <= pending_d;
            cmd_hold_q    <= cmd_hold_d;
            data_hold_q   <= data_hold_d;
            frame_start_q <= frame_start_d;
            cmd_err_q     <= cmd_err_d;
        end
    end

endmodule

// File: tb/tb_transfer_center_tx.sv
// Self-checking bench for transfer_center_tx. Expected frames are queued when
// stimulus is driven. A line monitor rebuilds each 8-clock frame from
// serial_out and compares it with the queue head.
module tb_transfer_center_tx;

    import transfer_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic peer_ready_in;
    logic ready_for_transfer_out;
    logic serial_out;
    logic frame_start;
    logic busy;
    logic cmd_err;

    transfer_center_tx_if req_if ();

    transfer_center_tx #(
        .IDLE_BYTE (8'h00)
    ) dut (
        .clk                    (clk),
        .rst                    (rst),
        .req                    (req_if),
        .peer_ready_in          (peer_ready_in),
        .ready_for_transfer_out (ready_for_transfer_out),
        .serial_out             (serial_out),
        .frame_start            (frame_start),
        .busy                   (busy),
        .cmd_err                (cmd_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] b;
        int         start;
    } exp_t;

    exp_t sb[$];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    // Edges since the last reset release. Load edges are 1, 9, 17, ...
    int edge_n;
    always @(posedge clk or posedge rst) begin
        if (rst) edge_n <= 0;
        else     edge_n <= edge_n + 1;
    end

    function automatic int next_load(input int a);
        int e;
        e = a + 1;
        while (e % 8 != 1) e++;
        return e;
    endfunction

    // Line monitor. At the negedge after edge k, serial_out holds bit
    // ((k-1) mod 8) of the frame loaded at the most recent load edge.
    logic [2:0] ph;
    logic [7:0] fb;
    logic       fs0;
    int         ones      = 0;
    int         fs_cnt    = 0;
    int         nz_frames = 0;

    always @(negedge clk) begin
        exp_t e;
        if (rst || edge_n == 0) begin
            ph  = 3'd7;
            fb  = '0;
            fs0 = 1'b0;
        end else begin
            ph = ph + 3'd1;
            fb = {fb[6:0], serial_out};
            if (ph == 3'd0) fs0 = frame_start;
            if (serial_out) ones++;
            if (frame_start) fs_cnt++;
            if (ph == 3'd7 && fb != 8'h00) begin
                nz_frames++;
                if (sb.size() == 0) begin
                    check("unexpected_frame", fb, 8'h00);
                end else begin
                    e = sb.pop_front();
                    check("frame_byte", fb, e.b);
                    if (e.start >= 0) check("frame_start_edge", edge_n - 7, e.start);
                    check("frame_start_pulse", fs0, 1'b1);
                end
            end
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        sb.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic send(input logic [7:0] c, input logic [7:0] d, output int acc);
        int n;
        n = 0;
        req_if.req_valid = 1'b1;
        req_if.req_cmd   = c;
        req_if.req_data  = d;
        while (!req_if.req_ready && n < 300) begin
            @(posedge clk);
            #1 n++;
        end
        check("accept_wait", n < 300, 1'b1);
        @(posedge clk);
        #1 acc = edge_n;
        req_if.req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((sb.size() != 0 || busy) && n < 400) begin
            @(posedge clk);
            #1 n++;
        end
        check("idle_timeout", n < 400, 1'b1);
    endtask

    task automatic wait_edge(input int target);
        int n;
        n = 0;
        while (edge_n != target && n < 100) begin
            @(posedge clk);
            #1 n++;
        end
        check("edge_wait", edge_n, target);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc, s, nz0, fs0c, ones0;

        req_if.req_valid = 1'b0;
        req_if.req_cmd   = '0;
        req_if.req_data  = '0;
        peer_ready_in    = 1'b1;
        rst              = 1'b1;
        #1;
        check("rst_serial", serial_out, 1'b0);
        check("rst_ready", req_if.req_ready, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_frame_start", frame_start, 1'b0);
        check("rst_cmd_err", cmd_err, 1'b0);

        // No requests: the line stays low.
        do_reset();
        ones0 = ones;
        repeat (40) @(posedge clk);
        #1;
        check("idle_ones", ones - ones0, 0);
        check("idle_frames", nz_frames, 0);

        // CMD_50 accepted on edge 2 goes out at load edge 9.
        do_reset();
        @(posedge clk);
        #1;
        fs0c = fs_cnt;
        send(CMD_50, 8'h00, acc);
        check("cmd50_accept_edge", acc, 2);
        sb.push_back('{b: CMD_50, start: next_load(acc)});
        check("cmd50_busy", busy, 1'b1);
        check("cmd50_ready_low", req_if.req_ready, 1'b0);
        wait_idle();
        check("cmd50_fs_count", fs_cnt - fs0c, 1);
        check("cmd50_busy_after", busy, 1'b0);

        // BINARY: command and data back to back. The peer drops once the
        // command frame has started, and the data frame must still follow.
        send(CMD_BINARY, 8'hA5, acc);
        s = next_load(acc);
        sb.push_back('{b: CMD_BINARY, start: s});
        sb.push_back('{b: 8'hA5, start: s + 8});
        wait_edge(s + 1);
        peer_ready_in = 1'b0;
        #1;
        check("rft_low", ready_for_transfer_out, 1'b0);
        wait_idle();

        // Peer not ready: CMD_90 is held while filler repeats.
        send(CMD_90, 8'h00, acc);
        nz0 = nz_frames;
        repeat (40) @(posedge clk);
        #1;
        check("hold_frames", nz_frames - nz0, 0);
        check("hold_ready_low", req_if.req_ready, 1'b0);
        check("hold_busy", busy, 1'b1);
        peer_ready_in = 1'b1;
        sb.push_back('{b: CMD_90, start: next_load(edge_n)});
        #1;
        check("rft_high", ready_for_transfer_out, 1'b1);
        wait_idle();

        // Illegal code: it is rejected and nothing goes on the line.
        nz0 = nz_frames;
        send(8'h09, 8'h00, acc);
        check("err_pulse", cmd_err, 1'b1);
        check("err_ready", req_if.req_ready, 1'b1);
        check("err_busy", busy, 1'b0);
        @(posedge clk);
        #1;
        check("err_pulse_end", cmd_err, 1'b0);
        repeat (24) @(posedge clk);
        #1;
        check("err_no_frame", nz_frames - nz0, 0);

        // Accept coincident with a load edge waits for the following one.
        s = 0;
        while (edge_n % 8 != 0 && s < 10) begin
            @(posedge clk);
            #1 s++;
        end
        send(CMD_FLUSH, 8'h00, acc);
        check("coincide_is_load_edge", acc % 8, 1);
        sb.push_back('{b: CMD_FLUSH, start: next_load(acc)});
        wait_idle();

        // Back-to-back requests.
        send(CMD_80, 8'h00, acc);
        sb.push_back('{b: CMD_80, start: next_load(acc)});
        send(CMD_100, 8'h00, acc);
        sb.push_back('{b: CMD_100, start: next_load(acc)});
        wait_idle();
        check("fs_matches_frames", fs_cnt, nz_frames);

        // Reset in the middle of a CMD_90 frame.
        send(CMD_90, 8'h00, acc);
        s = next_load(acc);
        sb.push_back('{b: CMD_90, start: s});
        wait_edge(s + 4);
        sb.delete();
        rst = 1'b1;
        #1;
        check("midrst_serial", serial_out, 1'b0);
        check("midrst_ready", req_if.req_ready, 1'b1);
        check("midrst_busy", busy, 1'b0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
        send(CMD_50, 8'h00, acc);
        sb.push_back('{b: CMD_50, start: next_load(acc)});
        wait_idle();

        check("sb_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
